// File: rtl/unidad_control.sv
// Control unit for the single-cycle ARM-subset core: combinational decode of
// cond/op/funct/rd, NZCV flag register, and condition-gated state strobes.
module unidad_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] ALU_flags,
  output logic       PC_src,
  output logic       mem_to_reg,
  output logic       mem_write,
  output logic [3:0] ALU_control,
  output logic       ALU_src,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic [1:0] reg_src
);

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;
  localparam logic [3:0] ALU_EOR = 4'b0100;
  localparam logic [3:0] ALU_MOV = 4'b0101;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  logic [3:0] r_flags;       // {N,Z,C,V}
  logic       w_n, w_z, w_c, w_v;
  logic [3:0] w_cmd;
  logic       w_s;
  logic       w_reg_w;
  logic       w_mem_w;
  logic       w_branch;
  logic       w_arith;
  logic       w_cmp;
  logic [1:0] w_flag_w;
  logic       w_pcs;
  logic       w_cond_ex;
  logic       w_exec;

  assign w_cmd = funct[4:1];
  assign w_s   = funct[0];
  assign {w_n, w_z, w_c, w_v} = r_flags;

  // Main decode: every output defaults to the op=11 (undefined) values.
  always_comb begin
    w_reg_w     = 1'b0;
    w_mem_w     = 1'b0;
    w_branch    = 1'b0;
    w_arith     = 1'b0;
    w_cmp       = 1'b0;
    mem_to_reg  = 1'b0;
    ALU_control = ALU_ADD;
    ALU_src     = 1'b0;
    imm_src     = 2'b00;
    reg_src     = 2'b00;
    unique case (op)
      OP_DP: begin
        ALU_src = funct[5];
        w_reg_w = 1'b1;
        case (w_cmd)
          CMD_ADD: begin ALU_control = ALU_ADD; w_arith = 1'b1; end
          CMD_SUB: begin ALU_control = ALU_SUB; w_arith = 1'b1; end
          CMD_AND: ALU_control = ALU_AND;
          CMD_ORR: ALU_control = ALU_ORR;
          CMD_EOR: ALU_control = ALU_EOR;
          CMD_MOV: ALU_control = ALU_MOV;
          CMD_CMP: begin
            ALU_control = ALU_SUB;
            w_arith     = 1'b1;
            w_cmp       = 1'b1;
            w_reg_w     = 1'b0;
          end
          default: begin
            ALU_control = ALU_ADD;
            w_reg_w     = 1'b0;
          end
        endcase
      end
      OP_MEM: begin
        ALU_src     = 1'b1;
        imm_src     = 2'b01;
        ALU_control = funct[3] ? ALU_ADD : ALU_SUB;
        if (funct[0]) begin
          mem_to_reg = 1'b1;
          w_reg_w    = 1'b1;
        end else begin
          w_mem_w = 1'b1;
          reg_src = 2'b10;
        end
      end
      OP_BR: begin
        ALU_src  = 1'b1;
        imm_src  = 2'b10;
        reg_src  = 2'b01;
        w_branch = 1'b1;
      end
      default: ;
    endcase
  end

  // Flag writes only exist for data-processing; C/V only from add/sub-type ops.
  always_comb begin
    w_flag_w = 2'b00;
    if (op == OP_DP) begin
      w_flag_w[1] = w_s | w_cmp;
      w_flag_w[0] = (w_s | w_cmp) & w_arith;
    end
  end

  assign w_pcs = w_branch | ((rd == 4'b1111) & w_reg_w);

  always_comb begin
    w_cond_ex = 1'b0;
    case (cond)
      4'b0000: w_cond_ex = w_z;
      4'b0001: w_cond_ex = ~w_z;
      4'b0010: w_cond_ex = w_c;
      4'b0011: w_cond_ex = ~w_c;
      4'b0100: w_cond_ex = w_n;
      4'b0101: w_cond_ex = ~w_n;
      4'b0110: w_cond_ex = w_v;
      4'b0111: w_cond_ex = ~w_v;
      4'b1000: w_cond_ex = w_c & ~w_z;
      4'b1001: w_cond_ex = ~w_c | w_z;
      4'b1010: w_cond_ex = (w_n == w_v);
      4'b1011: w_cond_ex = (w_n != w_v);
      4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
      4'b1101: w_cond_ex = w_z | (w_n != w_v);
      4'b1110: w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;
    endcase
  end

  // Strobes are suppressed while reset is held so nothing commits mid-reset.
  assign w_exec    = w_cond_ex & rst_n;
  assign PC_src    = w_pcs & w_exec;
  assign reg_write = w_reg_w & w_exec;
  assign mem_write = w_mem_w & w_exec;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flags <= 4'b0000;
    end else begin
      if (w_flag_w[1] & w_cond_ex) r_flags[3:2] <= ALU_flags[3:2];
      if (w_flag_w[0] & w_cond_ex) r_flags[1:0] <= ALU_flags[1:0];
    end
  end

endmodule

// File: tb/tb_unidad_control.sv
// Scoreboard bench for unidad_control: driver pushes reference-model outputs,
// monitor pops and compares on the falling edge.
module tb_unidad_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] ALU_flags;
  logic       PC_src, mem_to_reg, mem_write, ALU_src, reg_write;
  logic [3:0] ALU_control;
  logic [1:0] imm_src, reg_src;

  unidad_control dut (
    .clk(clk), .rst_n(rst_n), .cond(cond), .op(op), .funct(funct), .rd(rd),
    .ALU_flags(ALU_flags), .PC_src(PC_src), .mem_to_reg(mem_to_reg),
    .mem_write(mem_write), .ALU_control(ALU_control), .ALU_src(ALU_src),
    .imm_src(imm_src), .reg_write(reg_write), .reg_src(reg_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [13:0] v;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Architectural flags as the model sees them
  bit m_n, m_z, m_c, m_v;
  bit nx_n, nx_z, nx_c, nx_v;

  function automatic bit cond_pass(input logic [3:0] c);
    case (c)
      0: return m_z;            1: return !m_z;
      2: return m_c;            3: return !m_c;
      4: return m_n;            5: return !m_n;
      6: return m_v;            7: return !m_v;
      8: return m_c && !m_z;    9: return !m_c || m_z;
      10: return m_n == m_v;    11: return m_n != m_v;
      12: return !m_z && (m_n == m_v);
      13: return m_z || (m_n != m_v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Instruction-level reference: returns packed outputs and the flag-write pair.
  function automatic void model(input bit rst, input logic [3:0] c, input logic [1:0] o,
                                input logic [5:0] f, input logic [3:0] r,
                                output logic [13:0] res, output bit wnz, output bit wcv);
    bit ok, writes, memw, br, m2r, asrc;
    int alu;
    logic [1:0] imm, rsrc;
    int cmd;
    writes = 0; memw = 0; br = 0; m2r = 0; asrc = 0; alu = 0; imm = 0; rsrc = 0;
    wnz = 0; wcv = 0;
    cmd = int'(f[4:1]);
    if (o == 2'd0) begin
      asrc = f[5];
      writes = 1;
      case (cmd)
        4:  alu = 0;
        2:  alu = 1;
        0:  alu = 2;
        12: alu = 3;
        1:  alu = 4;
        13: alu = 5;
        10: begin alu = 1; writes = 0; end
        default: begin alu = 0; writes = 0; end
      endcase
      wnz = f[0] || cmd == 10;
      wcv = wnz && (cmd == 4 || cmd == 2 || cmd == 10);
    end else if (o == 2'd1) begin
      asrc = 1; imm = 2'b01;
      alu = f[3] ? 0 : 1;
      if (f[0]) begin m2r = 1; writes = 1; end
      else begin memw = 1; rsrc = 2'b10; end
    end else if (o == 2'd2) begin
      asrc = 1; imm = 2'b10; rsrc = 2'b01; br = 1;
    end
    ok = cond_pass(c) && rst;
    res = {(br || (r == 4'd15 && writes)) && ok, m2r, memw && ok, 4'(alu), asrc, imm,
           writes && ok, rsrc};
    wnz = wnz && cond_pass(c);
    wcv = wcv && cond_pass(c);
  endfunction

  // One instruction per cycle; inputs change 1 time unit after the rising edge.
  task automatic issue(input string nm, input bit rst, input logic [3:0] c,
                       input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                       input logic [3:0] fl);
    exp_t e;
    bit wnz, wcv;
    @(posedge clk);
    #1;
    m_n = nx_n; m_z = nx_z; m_c = nx_c; m_v = nx_v;
    rst_n = rst; cond = c; op = o; funct = f; rd = r; ALU_flags = fl;
    model(rst, c, o, f, r, e.v, wnz, wcv);
    e.nm = nm;
    q.push_back(e);
    if (!rst) begin
      nx_n = 0; nx_z = 0; nx_c = 0; nx_v = 0;
    end else begin
      if (wnz) begin nx_n = fl[3]; nx_z = fl[2]; end
      if (wcv) begin nx_c = fl[1]; nx_v = fl[0]; end
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [13:0] act;
      e = q.pop_front();
      act = {PC_src, mem_to_reg, mem_write, ALU_control, ALU_src, imm_src, reg_write, reg_src};
      total++;
      if (act !== e.v) begin
        bad++;
        $display("FAIL %s: got %b expected %b (PCs,M2R,MW,ALU,Asrc,Imm,RW,Rsrc)", e.nm, act, e.v);
      end
    end
  end

  initial begin
    rst_n = 0; cond = 4'he; op = 0; funct = 0; rd = 0; ALU_flags = 0;
    {m_n, m_z, m_c, m_v} = 4'b1111;
    {nx_n, nx_z, nx_c, nx_v} = 4'b1111;

    issue("reset_hold",  0, 4'he, 2'b00, 6'b001000, 4'd1,  4'h0);
    issue("dp_add_reg",  1, 4'he, 2'b00, 6'b001000, 4'd1,  4'h0);
    issue("dp_add_imm",  1, 4'he, 2'b00, 6'b101000, 4'd2,  4'h0);
    issue("branch_al",   1, 4'he, 2'b10, 6'b101000, 4'd0,  4'h0);
    issue("ne_after_rst",1, 4'h1, 2'b00, 6'b001000, 4'd3,  4'h0);
    issue("eq_after_rst",1, 4'h0, 2'b00, 6'b001000, 4'd3,  4'h0);
    issue("subs_setz",   1, 4'he, 2'b00, 6'b000101, 4'd4,  4'b0100);
    issue("eq_taken",    1, 4'h0, 2'b00, 6'b001000, 4'd5,  4'h0);
    issue("ne_skipped",  1, 4'h1, 2'b00, 6'b001000, 4'd5,  4'h0);
    issue("cmp_clrz",    1, 4'he, 2'b00, 6'b010100, 4'd0,  4'b0000);
    issue("eq_after_cmp",1, 4'h0, 2'b00, 6'b001000, 4'd5,  4'h0);
    issue("ldr",         1, 4'he, 2'b01, 6'b011001, 4'd6,  4'h0);
    issue("str_up",      1, 4'he, 2'b01, 6'b011000, 4'd6,  4'h0);
    issue("str_down",    1, 4'he, 2'b01, 6'b010000, 4'd6,  4'h0);
    issue("add_to_pc",   1, 4'he, 2'b00, 6'b001000, 4'd15, 4'hf);
    issue("add_pc_rst",  0, 4'he, 2'b00, 6'b001000, 4'd15, 4'hf);
    issue("cs_after_rst",1, 4'h2, 2'b00, 6'b001000, 4'd1,  4'h0);
    issue("op11",        1, 4'he, 2'b11, 6'b111111, 4'd15, 4'h0);
    issue("never",       1, 4'hf, 2'b10, 6'b000000, 4'd0,  4'h0);

    for (int i = 0; i < 600; i++) begin
      logic [3:0] c, r;
      logic [1:0] o;
      logic [5:0] f;
      c = ($urandom_range(0, 3) == 0) ? 4'he : 4'($urandom);
      o = 2'($urandom);
      f = 6'($urandom);
      if ($urandom_range(0, 2) == 0) f[0] = 1'b1;
      r = ($urandom_range(0, 3) == 0) ? 4'hf : 4'($urandom);
      issue("random", $urandom_range(0, 29) != 0, c, o, f, r, 4'($urandom));
    end

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unidad_control.md
Name: unidad_control

Overview:
- Control unit of the single-cycle ARM-subset processor.
- Decodes each instruction's cond, op, funct and rd fields and drives the datapath: PC mux, register file, data memory, ALU and immediate extender.
- Holds the architectural N/Z/C/V flag register and gates all state-changing strobes by condition-code evaluation.
- Decode is combinational (same-cycle); only the flag register is clocked.

Parameters:
- none

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- cond  in  4  instruction condition field [31:28]
- op  in  2  instruction class [27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined
- funct  in  6  instruction [25:20]: [5]=I, [4:1]=cmd, [0]=S; for memory [3]=U, [0]=L
- rd  in  4  destination register field [15:12]
- ALU_flags  in  4  current ALU result flags {N,Z,C,V}
- PC_src  out  1  1 = PC loads result (branch or write to R15)
- mem_to_reg  out  1  1 = writeback from data memory
- mem_write  out  1  data memory write enable
- ALU_control  out  4  ALU operation
- ALU_src  out  1  1 = ALU B operand from extended immediate
- imm_src  out  2  00 imm8 zero-extended, 01 imm12 zero-extended, 10 imm24 sign-extended ×4
- reg_write  out  1  register file write enable
- reg_src  out  2  [0]=1 read R15 as Rn; [1]=1 read Rd as Rm (store data)

Behaviour:
- ALU_control encoding: 0000 ADD, 0001 SUB, 0010 AND, 0011 ORR, 0100 EOR, 0101 pass-B (MOV).
- Data-processing (op=00), cmd mapping:
  - 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 0001 EOR, 1101 MOV, 1010 CMP (SUB with no register write).
  - Any other cmd: ALU_control=0000 and no register write.
  - ALU_src=funct[5], imm_src=00, reg_src=00, mem_to_reg=0, raw RegW=1 (0 for CMP/undefined cmd).
  - FlagW[1] (N,Z) = S or CMP.
  - FlagW[0] (C,V) = (S or CMP) and the cmd is ADD/SUB/CMP.
- Memory (op=01):
  - ALU_src=1, imm_src=01; ALU_control ADD if U=1, SUB if U=0.
  - L=1 (LDR): mem_to_reg=1, raw RegW=1, MemW=0, reg_src=00.
  - L=0 (STR): MemW=1, RegW=0, reg_src=10.
  - No flag write.
- Branch (op=10): ALU_src=1, imm_src=10, reg_src=01, ALU_control=ADD, Branch=1, RegW=0, MemW=0, no flag write.
- op=11: all enables 0; other outputs 0.
- PCS = Branch or (rd==1111 and raw RegW).
- CondEx is computed from cond and the stored flags (not ALU_flags):
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z
  - 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 treated as never (0).
- Gated outputs: PC_src=PCS&CondEx; reg_write=RegW&CondEx; mem_write=MemW&CondEx. All other outputs are ungated decode values.
- Flag register, on rising clk:
  - rst_n=0: flags <= 0000.
  - Otherwise: {N,Z} <= ALU_flags[3:2] if FlagW[1]&CondEx; {C,V} <= ALU_flags[1:0] if FlagW[0]&CondEx; else hold.
  - An instruction's own flag update affects CondEx only from the next cycle.
- While rst_n=0: PC_src, reg_write, mem_write forced 0; decode outputs still follow the inputs.
- After reset the flags are 0000, so EQ fails and NE passes.

Test Plan:
- Hold rst_n=0 one cycle, then release; cond=1110, op=00, funct=001000, rd=0001 -> reg_write=1, ALU_control=0000, ALU_src=0, imm_src=00, reg_src=00, PC_src=0, mem_write=0, mem_to_reg=0.
- cond=1110, op=00, funct=101000, rd=0010 -> same as above but ALU_src=1.
- cond=1110, op=10, funct=101000 -> PC_src=1, reg_write=0, mem_write=0, ALU_src=1, imm_src=10, reg_src=01, ALU_control=0000.
- Flag write and conditional execution:
  - SUBS: op=00, funct=000101, cond=1110, ALU_flags=0100, clock.
  - Then cond=0000 data-processing -> reg_write=1.
  - Then cond=0001 -> reg_write=0.
  - Then CMP (funct=010100) with ALU_flags=0000, clock, and cond=0000 -> reg_write=0.
- Memory:
  - op=01, funct=011001 (LDR) -> mem_to_reg=1, reg_write=1, imm_src=01, ALU_control=0000.
  - funct=011000 (STR) -> mem_write=1, reg_write=0, reg_src=10.
  - funct=010000 (STR, U=0) -> ALU_control=0001.
- Write to PC and reset behaviour:
  - Data-processing ADD with rd=1111, cond=1110 -> PC_src=1, reg_write=1.
  - Same inputs with rst_n=0 -> PC_src=0, reg_write=0, mem_write=0, and flags cleared at the next clock edge.
